// File: rtl/qpu_lsu_agu.sv
// Address-generation and issue stage ahead of the QPU LSU controller. It forms the effective
// address, flags misalignment, builds store lanes and tracks outstanding requests in a tag FIFO.
module qpu_lsu_agu #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned RD_W     = 5,
    parameter int unsigned OUTS_NUM = 2
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                agu_i_valid,
    output logic                agu_i_ready,
    input  logic                agu_i_load,
    input  logic [1:0]          agu_i_size,
    input  logic                agu_i_usign,
    input  logic [XLEN-1:0]     agu_i_rs1,
    input  logic [XLEN-1:0]     agu_i_imm,
    input  logic [XLEN-1:0]     agu_i_rs2,
    input  logic [RD_W-1:0]     agu_i_rd,

    output logic                lsu_icb_cmd_valid,
    input  logic                lsu_icb_cmd_ready,
    output logic [ADDR_W-1:0]   lsu_icb_cmd_addr,
    output logic                lsu_icb_cmd_read,
    output logic [XLEN-1:0]     lsu_icb_cmd_wdata,
    output logic [XLEN/8-1:0]   lsu_icb_cmd_wmask,

    output logic                agu_excp_valid,
    input  logic                agu_excp_ready,
    output logic [ADDR_W-1:0]   agu_excp_addr,
    output logic                agu_excp_ld,

    input  logic                lsu_rsp_done,
    output logic                wb_tag_valid,
    output logic [RD_W-1:0]     wb_rd,
    output logic [1:0]          wb_size,
    output logic                wb_usign,
    output logic [1:0]          wb_ofst,

    output logic                agu_active
);

    localparam int unsigned MaskW = XLEN / 8;
    localparam int unsigned PtrW  = (OUTS_NUM > 1) ? $clog2(OUTS_NUM) : 1;
    localparam int unsigned CntW  = $clog2(OUTS_NUM + 1);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   addr_sum;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_ofst;
    logic              req_misalign;
    logic [MaskW-1:0]  req_wmask;
    logic [XLEN-1:0]   req_wdata;

    assign addr_sum = agu_i_rs1 + agu_i_imm;
    assign req_addr = addr_sum[ADDR_W-1:0];
    assign req_ofst = addr_sum[1:0];

    always_comb begin
        req_misalign = 1'b0;
        req_wmask    = '0;
        req_wdata    = '0;
        unique case (agu_i_size)
            2'b00: begin
                req_wmask = MaskW'(1) << req_ofst;
                req_wdata = {(XLEN/8){agu_i_rs2[7:0]}};
            end
            2'b01: begin
                req_misalign = req_ofst[0];
                req_wmask    = MaskW'(3) << req_ofst;
                req_wdata    = {(XLEN/16){agu_i_rs2[15:0]}};
            end
            default: begin
                // Reserved size behaves as a word access.
                req_misalign = |req_ofst;
                req_wmask    = '1;
                req_wdata    = agu_i_rs2;
            end
        endcase
        if (agu_i_load) begin
            req_wmask = '0;
            req_wdata = '0;
        end
    end

    // ------------------------------------------------------------------
    // One-entry stage register
    // ------------------------------------------------------------------
    logic              st_vld_q, st_vld_d;
    logic              st_excp_q;
    logic [ADDR_W-1:0] st_addr_q;
    logic              st_read_q;
    logic [XLEN-1:0]   st_wdata_q;
    logic [MaskW-1:0]  st_wmask_q;
    logic [RD_W-1:0]   st_rd_q;
    logic [1:0]        st_size_q;
    logic              st_usign_q;

    logic agu_i_hsk;
    logic cmd_hsk;
    logic excp_hsk;
    logic stage_leaving;
    logic tag_full;

    assign agu_i_hsk     = agu_i_valid & agu_i_ready;
    assign cmd_hsk       = lsu_icb_cmd_valid & lsu_icb_cmd_ready;
    assign excp_hsk      = agu_excp_valid & agu_excp_ready;
    assign stage_leaving = cmd_hsk | excp_hsk;
    assign agu_i_ready   = ~st_vld_q | stage_leaving;

    always_comb begin
        st_vld_d = st_vld_q;
        if (agu_i_hsk) begin
            st_vld_d = 1'b1;
        end else if (stage_leaving) begin
            st_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_vld_q   <= 1'b0;
            st_excp_q  <= 1'b0;
            st_addr_q  <= '0;
            st_read_q  <= 1'b0;
            st_wdata_q <= '0;
            st_wmask_q <= '0;
            st_rd_q    <= '0;
            st_size_q  <= '0;
            st_usign_q <= 1'b0;
        end else begin
            st_vld_q <= st_vld_d;
            if (agu_i_hsk) begin
                st_excp_q  <= req_misalign;
                st_addr_q  <= req_addr;
                st_read_q  <= agu_i_load;
                st_wdata_q <= req_wdata;
                st_wmask_q <= req_wmask;
                st_rd_q    <= agu_i_rd;
                st_size_q  <= agu_i_size;
                st_usign_q <= agu_i_usign;
            end
        end
    end

    assign lsu_icb_cmd_valid = st_vld_q & ~st_excp_q & ~tag_full;
    assign lsu_icb_cmd_addr  = st_addr_q;
    assign lsu_icb_cmd_read  = st_read_q;
    assign lsu_icb_cmd_wdata = st_wdata_q;
    assign lsu_icb_cmd_wmask = st_wmask_q;

    assign agu_excp_valid = st_vld_q & st_excp_q;
    assign agu_excp_addr  = agu_excp_valid ? st_addr_q : '0;
    assign agu_excp_ld    = agu_excp_valid & st_read_q;

    // ------------------------------------------------------------------
    // Tag FIFO: write-back metadata for every issued command
    // ------------------------------------------------------------------
    logic [RD_W-1:0] tag_rd_q    [OUTS_NUM];
    logic [1:0]      tag_size_q  [OUTS_NUM];
    logic            tag_usign_q [OUTS_NUM];
    logic [1:0]      tag_ofst_q  [OUTS_NUM];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tag_push;
    logic            tag_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(OUTS_NUM - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign tag_full     = (cnt_q == CntW'(OUTS_NUM));
    assign wb_tag_valid = (cnt_q != '0);
    assign tag_push     = cmd_hsk;
    assign tag_pop      = lsu_rsp_done & wb_tag_valid;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (tag_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (tag_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({tag_push, tag_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < OUTS_NUM; i++) begin
                tag_rd_q[i]    <= '0;
                tag_size_q[i]  <= '0;
                tag_usign_q[i] <= 1'b0;
                tag_ofst_q[i]  <= '0;
            end
        end else if (tag_push) begin
            tag_rd_q[wr_ptr_q]    <= st_rd_q;
            tag_size_q[wr_ptr_q]  <= st_size_q;
            tag_usign_q[wr_ptr_q] <= st_usign_q;
            tag_ofst_q[wr_ptr_q]  <= st_addr_q[1:0];
        end
    end

    // Head entry is selected by the registered read pointer only.
    assign wb_rd    = tag_rd_q[rd_ptr_q];
    assign wb_size  = tag_size_q[rd_ptr_q];
    assign wb_usign = tag_usign_q[rd_ptr_q];
    assign wb_ofst  = tag_ofst_q[rd_ptr_q];

    assign agu_active = st_vld_q | wb_tag_valid;

endmodule

// File: tb/tb_qpu_lsu_agu.sv
// Scoreboard bench for qpu_lsu_agu: directed requests push expected commands, exceptions and
// tags into queues; a negedge monitor pops and compares them whenever the DUT hands one off.
module tb_qpu_lsu_agu;

    logic        clk = 1'b0;
    logic        rst;
    logic        agu_i_valid, agu_i_ready, agu_i_load, agu_i_usign;
    logic [1:0]  agu_i_size;
    logic [31:0] agu_i_rs1, agu_i_imm, agu_i_rs2;
    logic [4:0]  agu_i_rd;
    logic        lsu_icb_cmd_valid, lsu_icb_cmd_ready, lsu_icb_cmd_read;
    logic [31:0] lsu_icb_cmd_addr, lsu_icb_cmd_wdata;
    logic [3:0]  lsu_icb_cmd_wmask;
    logic        agu_excp_valid, agu_excp_ready, agu_excp_ld;
    logic [31:0] agu_excp_addr;
    logic        lsu_rsp_done, wb_tag_valid, wb_usign, agu_active;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_size, wb_ofst;

    typedef struct packed {
        logic [31:0] addr;
        logic        read;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } cmd_t;
    typedef struct packed {
        logic [4:0] rd;
        logic [1:0] size;
        logic       usign;
        logic [1:0] ofst;
    } tag_t;
    typedef struct packed {
        logic [31:0] addr;
        logic        ld;
    } excp_t;

    cmd_t  cmd_q[$];
    tag_t  tag_q[$];
    excp_t excp_q[$];
    cmd_t  mon_c;
    tag_t  mon_t;
    excp_t mon_x;
    int    errors = 0;
    int    checks = 0;

    qpu_lsu_agu #(.XLEN(32), .ADDR_W(32), .RD_W(5), .OUTS_NUM(2)) dut (
        .clk(clk), .rst(rst),
        .agu_i_valid(agu_i_valid), .agu_i_ready(agu_i_ready), .agu_i_load(agu_i_load),
        .agu_i_size(agu_i_size), .agu_i_usign(agu_i_usign), .agu_i_rs1(agu_i_rs1),
        .agu_i_imm(agu_i_imm), .agu_i_rs2(agu_i_rs2), .agu_i_rd(agu_i_rd),
        .lsu_icb_cmd_valid(lsu_icb_cmd_valid), .lsu_icb_cmd_ready(lsu_icb_cmd_ready),
        .lsu_icb_cmd_addr(lsu_icb_cmd_addr), .lsu_icb_cmd_read(lsu_icb_cmd_read),
        .lsu_icb_cmd_wdata(lsu_icb_cmd_wdata), .lsu_icb_cmd_wmask(lsu_icb_cmd_wmask),
        .agu_excp_valid(agu_excp_valid), .agu_excp_ready(agu_excp_ready),
        .agu_excp_addr(agu_excp_addr), .agu_excp_ld(agu_excp_ld),
        .lsu_rsp_done(lsu_rsp_done), .wb_tag_valid(wb_tag_valid), .wb_rd(wb_rd),
        .wb_size(wb_size), .wb_usign(wb_usign), .wb_ofst(wb_ofst), .agu_active(agu_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: compare every handoff against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (lsu_icb_cmd_valid && lsu_icb_cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_unexpected: got addr 0x%0h, expected no command",
                             lsu_icb_cmd_addr);
                end else begin
                    mon_c = cmd_q.pop_front();
                    chk("cmd_addr", lsu_icb_cmd_addr, mon_c.addr);
                    chk("cmd_read", {31'd0, lsu_icb_cmd_read}, {31'd0, mon_c.read});
                    chk("cmd_wdata", lsu_icb_cmd_wdata, mon_c.wdata);
                    chk("cmd_wmask", {28'd0, lsu_icb_cmd_wmask}, {28'd0, mon_c.wmask});
                end
            end
            if (agu_excp_valid && agu_excp_ready) begin
                if (excp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL excp_unexpected: got addr 0x%0h, expected no exception",
                             agu_excp_addr);
                end else begin
                    mon_x = excp_q.pop_front();
                    chk("excp_addr", agu_excp_addr, mon_x.addr);
                    chk("excp_ld", {31'd0, agu_excp_ld}, {31'd0, mon_x.ld});
                end
            end
            if (lsu_rsp_done && wb_tag_valid) begin
                if (tag_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tag_unexpected: got rd %0d, expected empty tag FIFO", wb_rd);
                end else begin
                    mon_t = tag_q.pop_front();
                    chk("wb_rd", {27'd0, wb_rd}, {27'd0, mon_t.rd});
                    chk("wb_size", {30'd0, wb_size}, {30'd0, mon_t.size});
                    chk("wb_usign", {31'd0, wb_usign}, {31'd0, mon_t.usign});
                    chk("wb_ofst", {30'd0, wb_ofst}, {30'd0, mon_t.ofst});
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the dispatch handshake edge.
    task automatic send(input logic ld, input logic [1:0] sz, input logic us,
                        input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic excp, input logic [31:0] eaddr,
                        input logic [31:0] ewdata, input logic [3:0] ewmask);
        cmd_t  c;
        tag_t  t;
        excp_t x;
        int    n;
        if (excp) begin
            x.addr = eaddr;
            x.ld   = ld;
            excp_q.push_back(x);
        end else begin
            c.addr  = eaddr;
            c.read  = ld;
            c.wdata = ewdata;
            c.wmask = ewmask;
            cmd_q.push_back(c);
            t.rd    = rd;
            t.size  = sz;
            t.usign = us;
            t.ofst  = eaddr[1:0];
            tag_q.push_back(t);
        end
        agu_i_valid = 1'b1;
        agu_i_load  = ld;
        agu_i_size  = sz;
        agu_i_usign = us;
        agu_i_rs1   = rs1;
        agu_i_imm   = imm;
        agu_i_rs2   = rs2;
        agu_i_rd    = rd;
        n = 0;
        @(negedge clk);
        while (!agu_i_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!agu_i_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got agu_i_ready=0 for 100 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        agu_i_valid = 1'b0;
    endtask

    task automatic pulse_done(input int n);
        lsu_rsp_done = 1'b1;
        step(n);
        lsu_rsp_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        agu_i_valid = 1'b0;
        agu_i_load = 1'b0;
        agu_i_size = 2'b00;
        agu_i_usign = 1'b0;
        agu_i_rs1 = '0;
        agu_i_imm = '0;
        agu_i_rs2 = '0;
        agu_i_rd = '0;
        lsu_icb_cmd_ready = 1'b1;
        agu_excp_ready = 1'b1;
        lsu_rsp_done = 1'b0;

        @(negedge clk);
        chk("rst_i_ready", {31'd0, agu_i_ready}, 32'd1);
        chk("rst_cmd_valid", {31'd0, lsu_icb_cmd_valid}, 32'd0);
        chk("rst_excp_valid", {31'd0, agu_excp_valid}, 32'd0);
        chk("rst_tag_valid", {31'd0, wb_tag_valid}, 32'd0);
        chk("rst_active", {31'd0, agu_active}, 32'd0);
        chk("rst_cmd_addr", lsu_icb_cmd_addr, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        step(1);
        rst = 1'b0;
        step(1);

        // Aligned word store with one-cycle issue latency and next-cycle tag.
        send(1'b0, 2'b10, 1'b0, 32'h100, 32'd4, 32'hA1B2C3D4, 5'd0,
             1'b0, 32'h104, 32'hA1B2C3D4, 4'hF);
        @(negedge clk);
        chk("lat_cmd_valid", {31'd0, lsu_icb_cmd_valid}, 32'd1);
        step(1);
        @(negedge clk);
        chk("tag_visible", {31'd0, wb_tag_valid}, 32'd1);
        step(1);
        pulse_done(1);

        // Signed byte load at offset 3, then half store at offset 2, back to back.
        send(1'b1, 2'b00, 1'b0, 32'h103, 32'd0, 32'd0, 5'd7, 1'b0, 32'h103, 32'd0, 4'h0);
        send(1'b0, 2'b01, 1'b0, 32'h1FE, 32'd4, 32'h0000BEEF, 5'd0,
             1'b0, 32'h202, 32'hBEEFBEEF, 4'hC);
        pulse_done(2);

        // Unsigned half load with negative offset; reserved size behaves as word.
        send(1'b1, 2'b01, 1'b1, 32'h300, 32'hFFFFFFFE, 32'd0, 5'd5, 1'b0, 32'h2FE, 32'd0, 4'h0);
        send(1'b0, 2'b11, 1'b0, 32'h40, 32'd0, 32'h11223344, 5'd0,
             1'b0, 32'h40, 32'h11223344, 4'hF);
        pulse_done(2);

        // Misaligned half store: exception only, no tag.
        send(1'b0, 2'b01, 1'b0, 32'h41, 32'd0, 32'h1234, 5'd0, 1'b1, 32'h41, 32'd0, 4'h0);
        step(1);
        @(negedge clk);
        chk("excp_st_no_tag", {31'd0, wb_tag_valid}, 32'd0);
        step(1);

        // Misaligned word load held by a stalled exception port.
        agu_excp_ready = 1'b0;
        send(1'b1, 2'b10, 1'b0, 32'h101, 32'd0, 32'd0, 5'd4, 1'b1, 32'h101, 32'd0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("excp_hold_valid", {31'd0, agu_excp_valid}, 32'd1);
            chk("excp_hold_addr", agu_excp_addr, 32'h101);
            chk("excp_hold_ld", {31'd0, agu_excp_ld}, 32'd1);
            chk("excp_hold_cmd", {31'd0, lsu_icb_cmd_valid}, 32'd0);
            chk("excp_hold_ready", {31'd0, agu_i_ready}, 32'd0);
            chk("excp_hold_tag", {31'd0, wb_tag_valid}, 32'd0);
            step(1);
        end
        agu_excp_ready = 1'b1;
        @(negedge clk);
        chk("excp_leave_ready", {31'd0, agu_i_ready}, 32'd1);
        step(1);
        @(negedge clk);
        chk("excp_gone", {31'd0, agu_excp_valid}, 32'd0);
        step(1);

        // Response with empty FIFO is ignored.
        pulse_done(1);
        @(negedge clk);
        chk("empty_done_tag", {31'd0, wb_tag_valid}, 32'd0);
        chk("empty_done_active", {31'd0, agu_active}, 32'd0);
        step(1);

        // Outstanding limit: third load waits for a pop, no same-cycle bypass.
        send(1'b1, 2'b10, 1'b0, 32'h200, 32'd0, 32'd0, 5'd1, 1'b0, 32'h200, 32'd0, 4'h0);
        send(1'b1, 2'b10, 1'b0, 32'h204, 32'd0, 32'd0, 5'd2, 1'b0, 32'h204, 32'd0, 4'h0);
        send(1'b1, 2'b10, 1'b0, 32'h208, 32'd0, 32'd0, 5'd3, 1'b0, 32'h208, 32'd0, 4'h0);
        @(negedge clk);
        chk("full_cmd_valid", {31'd0, lsu_icb_cmd_valid}, 32'd0);
        chk("full_i_ready", {31'd0, agu_i_ready}, 32'd0);
        chk("full_wb_rd", {27'd0, wb_rd}, 32'd1);
        step(1);
        @(negedge clk);
        chk("full_hold_valid", {31'd0, lsu_icb_cmd_valid}, 32'd0);
        step(1);
        lsu_rsp_done = 1'b1;
        @(negedge clk);
        chk("pop_no_bypass", {31'd0, lsu_icb_cmd_valid}, 32'd0);
        step(1);
        lsu_rsp_done = 1'b0;
        @(negedge clk);
        chk("pop_wb_rd_adv", {27'd0, wb_rd}, 32'd2);
        chk("pop_reissue", {31'd0, lsu_icb_cmd_valid}, 32'd1);
        step(1);
        pulse_done(2);
        @(negedge clk);
        chk("drained_tag", {31'd0, wb_tag_valid}, 32'd0);
        step(1);

        // Address wrap, then asynchronous reset while the command is pending.
        lsu_icb_cmd_ready = 1'b0;
        send(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'd8, 32'd0, 5'd9, 1'b0, 32'h4, 32'd0, 4'h0);
        @(negedge clk);
        chk("wrap_valid", {31'd0, lsu_icb_cmd_valid}, 32'd1);
        chk("wrap_addr", lsu_icb_cmd_addr, 32'h4);
        step(2);
        @(negedge clk);
        chk("wrap_hold_valid", {31'd0, lsu_icb_cmd_valid}, 32'd1);
        chk("wrap_hold_addr", lsu_icb_cmd_addr, 32'h4);
        step(1);
        rst = 1'b1;
        #1;
        chk("arst_cmd_valid", {31'd0, lsu_icb_cmd_valid}, 32'd0);
        chk("arst_tag_valid", {31'd0, wb_tag_valid}, 32'd0);
        chk("arst_active", {31'd0, agu_active}, 32'd0);
        chk("arst_i_ready", {31'd0, agu_i_ready}, 32'd1);
        cmd_q.delete();
        tag_q.delete();
        step(1);
        rst = 1'b0;
        lsu_icb_cmd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {30'd0, lsu_icb_cmd_valid, agu_excp_valid}, 32'd0);
            step(1);
        end

        // Recovery: byte store at offset 1.
        send(1'b0, 2'b00, 1'b0, 32'h10, 32'd1, 32'h5A, 5'd0, 1'b0, 32'h11, 32'h5A5A5A5A, 4'h2);
        step(1);
        pulse_done(1);
        step(2);

        chk("cmd_q_empty", cmd_q.size(), 32'd0);
        chk("tag_q_empty", tag_q.size(), 32'd0);
        chk("excp_q_empty", excp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
